// File: rtl/hv_abist_rsp_if.sv
// Bus bundle for the HV analog BIST responder: BIST requests and fault injection in,
// emulated analog fault flags and ADC samples out.
interface hv_abist_rsp_if #(
    parameter int ADC_DW = 10
);
    logic              i_bist_hv_ov;
    logic              i_bist_hv_ot;
    logic              i_bist_hv_opscod;
    logic              i_bist_hv_oc;
    logic              i_bist_hv_sc;
    logic              i_bist_hv_adc;
    logic [5:0]        i_fault_inj;

    logic              o_hv_vcc_ov;
    logic              o_hv_ot;
    logic              o_hv_desat_flt;
    logic              o_hv_oc;
    logic              o_hv_scp_flt;
    logic              o_hv_adc_rdy1;
    logic              o_hv_adc_rdy2;
    logic [ADC_DW-1:0] o_hv_adc_data1;
    logic [ADC_DW-1:0] o_hv_adc_data2;

    modport master (
        output i_bist_hv_ov, i_bist_hv_ot, i_bist_hv_opscod, i_bist_hv_oc,
               i_bist_hv_sc, i_bist_hv_adc, i_fault_inj,
        input  o_hv_vcc_ov, o_hv_ot, o_hv_desat_flt, o_hv_oc, o_hv_scp_flt,
               o_hv_adc_rdy1, o_hv_adc_rdy2, o_hv_adc_data1, o_hv_adc_data2
    );

    modport slave (
        input  i_bist_hv_ov, i_bist_hv_ot, i_bist_hv_opscod, i_bist_hv_oc,
               i_bist_hv_sc, i_bist_hv_adc, i_fault_inj,
        output o_hv_vcc_ov, o_hv_ot, o_hv_desat_flt, o_hv_oc, o_hv_scp_flt,
               o_hv_adc_rdy1, o_hv_adc_rdy2, o_hv_adc_data1, o_hv_adc_data2
    );
endinterface

// File: rtl/hv_abist_rsp.sv
// Emulates the HV analog front end during BIST: five delayed fault flags plus a
// periodic two-channel ADC sample stream, each with an optional forced-fail mode.
module hv_abist_rsp #(
    parameter int                CLK_M   = 48,
    parameter int                ADC_DW  = 10,
    parameter int                OV_DLY  = 10 * CLK_M,
    parameter int                FLT_DLY = CLK_M / 2,
    parameter int                ADC_DLY = 20 * CLK_M,
    parameter int                ADC_PER = 4 * CLK_M,
    parameter logic [ADC_DW-1:0] ADC_MID = ADC_DW'(10'h200),
    parameter logic [ADC_DW-1:0] ADC_BAD = ADC_DW'(10'h000)
) (
    input logic           i_clk,
    input logic           i_rst,
    hv_abist_rsp_if.slave bus
);

    localparam int MAX_A   = (OV_DLY > FLT_DLY) ? OV_DLY : FLT_DLY;
    localparam int MAX_B   = (ADC_DLY > ADC_PER) ? ADC_DLY : ADC_PER;
    localparam int MAX_DLY = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(MAX_DLY + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ASSERT = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam logic [1:0] AD_IDLE     = 2'd0;
    localparam logic [1:0] AD_FIRST    = 2'd1;
    localparam logic [1:0] AD_PERIODIC = 2'd2;

    localparam logic [CW-1:0] ADC_FIRST_LAST = CW'(ADC_DLY - 1);
    localparam logic [CW-1:0] ADC_PER_LAST   = CW'(ADC_PER - 1);

    logic [5:0] req;
    logic [5:0] req_q;
    logic [5:0] armed;
    logic [5:0] rise;
    logic [4:0] flag;

    assign req  = {bus.i_bist_hv_adc, bus.i_bist_hv_sc, bus.i_bist_hv_oc,
                   bus.i_bist_hv_opscod, bus.i_bist_hv_ot, bus.i_bist_hv_ov};
    // A request still high across reset release must be seen low before it counts as a rise
    assign rise = req & ~req_q & armed;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            req_q <= '0;
            armed <= '0;
        end else begin
            req_q <= req;
            armed <= armed | ~req;
        end
    end

    for (genvar gi = 0; gi < 5; gi++) begin : g_flag
        localparam int            DLY  = (gi == 0) ? OV_DLY : FLT_DLY;
        localparam logic [CW-1:0] LAST = CW'(DLY - 1);

        logic [1:0]    state;
        logic [1:0]    state_nxt;
        logic [CW-1:0] cnt;
        logic          flag_r;

        always_comb begin
            state_nxt = state;
            case (state)
                ST_IDLE:   if (rise[gi]) state_nxt = bus.i_fault_inj[gi] ? ST_HOLD : ST_WAIT;
                ST_WAIT:   if (!req[gi]) state_nxt = ST_IDLE;
                           else if (cnt == LAST) state_nxt = ST_ASSERT;
                ST_ASSERT: if (!req[gi]) state_nxt = ST_IDLE;
                ST_HOLD:   if (!req[gi]) state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end

        // Flag is registered from the next state so it changes on the same edge as the FSM
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                state  <= ST_IDLE;
                cnt    <= '0;
                flag_r <= 1'b0;
            end else begin
                state  <= state_nxt;
                flag_r <= (state_nxt == ST_ASSERT);
                if (state == ST_IDLE)
                    cnt <= '0;
                else if (state == ST_WAIT && cnt != '1)
                    cnt <= cnt + 1'b1;
            end
        end

        assign flag[gi] = flag_r;
    end

    assign bus.o_hv_vcc_ov    = flag[0];
    assign bus.o_hv_ot        = flag[1];
    assign bus.o_hv_desat_flt = flag[2];
    assign bus.o_hv_oc        = flag[3];
    assign bus.o_hv_scp_flt   = flag[4];

    logic [1:0]        adc_state;
    logic [CW-1:0]     adc_cnt;
    logic              adc_bad;
    logic              adc_phase;
    logic              adc_rdy;
    logic [ADC_DW-1:0] adc_d1;
    logic [ADC_DW-1:0] adc_d2;
    logic [CW-1:0]     adc_last;

    assign adc_last = (adc_state == AD_FIRST) ? ADC_FIRST_LAST : ADC_PER_LAST;

    // Sample stream: first sample after the startup delay, then one per period;
    // channel 1 wobbles upward from mid-scale, channel 2 downward
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            adc_state <= AD_IDLE;
            adc_cnt   <= '0;
            adc_bad   <= 1'b0;
            adc_phase <= 1'b0;
            adc_rdy   <= 1'b0;
            adc_d1    <= '0;
            adc_d2    <= '0;
        end else begin
            adc_rdy <= 1'b0;
            case (adc_state)
                AD_IDLE: begin
                    if (rise[5]) begin
                        adc_state <= AD_FIRST;
                        adc_cnt   <= '0;
                        adc_bad   <= bus.i_fault_inj[5];
                        adc_phase <= 1'b0;
                    end
                end
                AD_FIRST, AD_PERIODIC: begin
                    if (!req[5]) begin
                        adc_state <= AD_IDLE;
                        adc_cnt   <= '0;
                        adc_d1    <= '0;
                        adc_d2    <= '0;
                    end else if (adc_cnt == adc_last) begin
                        adc_state <= AD_PERIODIC;
                        adc_cnt   <= '0;
                        adc_rdy   <= 1'b1;
                        adc_phase <= ~adc_phase;
                        adc_d1    <= adc_bad ? ADC_BAD : (adc_phase ? ADC_MID + ADC_DW'(1) : ADC_MID);
                        adc_d2    <= adc_bad ? ADC_BAD : (adc_phase ? ADC_MID - ADC_DW'(1) : ADC_MID);
                    end else if (adc_cnt != '1) begin
                        adc_cnt <= adc_cnt + 1'b1;
                    end
                end
                default: adc_state <= AD_IDLE;
            endcase
        end
    end

    assign bus.o_hv_adc_rdy1  = adc_rdy;
    assign bus.o_hv_adc_rdy2  = adc_rdy;
    assign bus.o_hv_adc_data1 = adc_d1;
    assign bus.o_hv_adc_data2 = adc_d2;

endmodule

// File: tb/tb_hv_abist_rsp.sv
// Directed bench for hv_abist_rsp at CLK_M=48: expected flag rises and ADC samples are
// queued when requests are driven and matched by a negedge monitor.
module tb_hv_abist_rsp;

    localparam int OV_DLY  = 480;
    localparam int FLT_DLY = 24;
    localparam int ADC_DLY = 960;
    localparam int ADC_PER = 192;

    typedef struct {
        int item;
        int cyc;
    } flag_exp_t;

    typedef struct {
        int         cyc;
        logic [9:0] d1;
        logic [9:0] d2;
    } adc_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   ov_hi = 0;
    int   oc_hi = 0;

    flag_exp_t flag_q[$];
    adc_exp_t  adc_q[$];
    logic [4:0] prev_f = '0;

    hv_abist_rsp_if #(.ADC_DW(10)) bus ();

    hv_abist_rsp #(.CLK_M(48), .ADC_DW(10)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    wire [4:0] mon_f = {bus.o_hv_scp_flt, bus.o_hv_oc, bus.o_hv_desat_flt,
                        bus.o_hv_ot, bus.o_hv_vcc_ov};

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic apply_stimulus(input int item, input logic val, output int rise_cyc);
        @(negedge clk);
        case (item)
            0: bus.i_bist_hv_ov     = val;
            1: bus.i_bist_hv_ot     = val;
            2: bus.i_bist_hv_opscod = val;
            3: bus.i_bist_hv_oc     = val;
            4: bus.i_bist_hv_sc     = val;
            default: bus.i_bist_hv_adc = val;
        endcase
        rise_cyc = cyc + 1;
    endtask

    task automatic wait_flags(input int budget, input string tag);
        int n = 0;
        while (flag_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_output(tag, flag_q.size(), 0);
    endtask

    task automatic wait_adc(input int budget, input string tag);
        int n = 0;
        while (adc_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_output(tag, adc_q.size(), 0);
    endtask

    // Matches every flag rise and every ADC pulse against the queued expectations
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 5; i++) begin
                if (mon_f[i] && !prev_f[i]) begin
                    if (flag_q.size() == 0) begin
                        checks++;
                        errors++;
                        $error("[TB] FAIL flag_unexpected item=%0d observed=rise required=none cycle=%0d", i, cyc);
                    end else begin
                        flag_exp_t fe;
                        fe = flag_q.pop_front();
                        check_output("flag_item", i, fe.item);
                        check_output("flag_cycle", cyc, fe.cyc);
                    end
                end
            end
            if (bus.o_hv_adc_rdy1 || bus.o_hv_adc_rdy2) begin
                check_output("rdy_pair", bus.o_hv_adc_rdy2, bus.o_hv_adc_rdy1);
                if (adc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("[TB] FAIL adc_unexpected observed=rdy required=none cycle=%0d", cyc);
                end else begin
                    adc_exp_t ae;
                    ae = adc_q.pop_front();
                    check_output("adc_cycle", cyc, ae.cyc);
                    check_output("adc_data1", bus.o_hv_adc_data1, ae.d1);
                    check_output("adc_data2", bus.o_hv_adc_data2, ae.d2);
                end
            end
            if (bus.o_hv_vcc_ov) ov_hi <= ov_hi + 1;
            if (bus.o_hv_oc) oc_hi <= oc_hi + 1;
        end
        prev_f <= mon_f;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r;
        int start;

        bus.i_bist_hv_ov     = 1'b0;
        bus.i_bist_hv_ot     = 1'b0;
        bus.i_bist_hv_opscod = 1'b0;
        bus.i_bist_hv_oc     = 1'b0;
        bus.i_bist_hv_sc     = 1'b0;
        bus.i_bist_hv_adc    = 1'b0;
        bus.i_fault_inj      = 6'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_output("rst_flags", mon_f, 5'b0);
        check_output("rst_rdy", {bus.o_hv_adc_rdy1, bus.o_hv_adc_rdy2}, 2'b0);
        check_output("rst_data", {bus.o_hv_adc_data1, bus.o_hv_adc_data2}, 20'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // OV response delay, then drop one cycle after the flag appears
        apply_stimulus(0, 1'b1, r);
        flag_q.push_back('{item: 0, cyc: r + OV_DLY});
        wait_flags(OV_DLY + 20, "ov_timeout");
        @(negedge clk);
        check_output("ov_still_high", bus.o_hv_vcc_ov, 1'b1);
        bus.i_bist_hv_ov = 1'b0;
        @(negedge clk);
        check_output("ov_dropped", bus.o_hv_vcc_ov, 1'b0);

        // OT short pulse aborts, re-request one cycle later responds
        apply_stimulus(1, 1'b1, r);
        repeat (9) @(negedge clk);
        apply_stimulus(1, 1'b0, r);
        apply_stimulus(1, 1'b1, r);
        flag_q.push_back('{item: 1, cyc: r + FLT_DLY});
        wait_flags(FLT_DLY + 20, "ot_timeout");
        apply_stimulus(1, 1'b0, r);
        @(negedge clk);
        check_output("ot_dropped", bus.o_hv_ot, 1'b0);

        // OC with forced fail never asserts; clearing injection mid-request is ignored
        bus.i_fault_inj = 6'b001000;
        apply_stimulus(3, 1'b1, r);
        #1 start = oc_hi;
        repeat (1000) @(negedge clk);
        bus.i_fault_inj = 6'b000000;
        repeat (1000) @(negedge clk);
        #1 check_output("oc_inj_quiet", oc_hi - start, 0);
        apply_stimulus(3, 1'b0, r);
        apply_stimulus(3, 1'b1, r);
        flag_q.push_back('{item: 3, cyc: r + FLT_DLY});
        wait_flags(FLT_DLY + 20, "oc_timeout");
        apply_stimulus(3, 1'b0, r);

        // ADC nominal stream
        apply_stimulus(5, 1'b1, r);
        adc_q.push_back('{cyc: r + ADC_DLY,               d1: 10'h200, d2: 10'h200});
        adc_q.push_back('{cyc: r + ADC_DLY + ADC_PER,     d1: 10'h201, d2: 10'h1FF});
        adc_q.push_back('{cyc: r + ADC_DLY + 2 * ADC_PER, d1: 10'h200, d2: 10'h200});
        wait_adc(ADC_DLY + 3 * ADC_PER, "adc_timeout");
        @(negedge clk);
        check_output("adc_rdy_low", bus.o_hv_adc_rdy1, 1'b0);
        check_output("adc_hold", {bus.o_hv_adc_data1, bus.o_hv_adc_data2}, {10'h200, 10'h200});
        bus.i_bist_hv_adc = 1'b0;
        @(negedge clk);
        check_output("adc_drop_data", {bus.o_hv_adc_data1, bus.o_hv_adc_data2}, 20'h0);
        repeat (ADC_PER + 4) @(negedge clk);

        // Reset in the middle of an OV wait; a still-high request is not a rise
        apply_stimulus(0, 1'b1, r);
        repeat (299) @(negedge clk);
        rst = 1'b1;
        #1 check_output("rst_mid_flag", bus.o_hv_vcc_ov, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1 start = ov_hi;
        repeat (OV_DLY + 100) @(negedge clk);
        #1 check_output("ov_after_rst_quiet", ov_hi - start, 0);
        apply_stimulus(0, 1'b0, r);
        apply_stimulus(0, 1'b1, r);
        flag_q.push_back('{item: 0, cyc: r + OV_DLY});
        wait_flags(OV_DLY + 20, "ov_fresh_timeout");
        apply_stimulus(0, 1'b0, r);

        // ADC forced-fail codes, injection cleared mid-request has no effect
        bus.i_fault_inj = 6'b100000;
        apply_stimulus(5, 1'b1, r);
        adc_q.push_back('{cyc: r + ADC_DLY,           d1: 10'h000, d2: 10'h000});
        adc_q.push_back('{cyc: r + ADC_DLY + ADC_PER, d1: 10'h000, d2: 10'h000});
        repeat (100) @(negedge clk);
        bus.i_fault_inj = 6'b000000;
        wait_adc(ADC_DLY + 2 * ADC_PER, "adc_bad_timeout");
        apply_stimulus(5, 1'b0, r);
        repeat (4) @(negedge clk);

        // Concurrent ADC and OT requests
        @(negedge clk);
        bus.i_bist_hv_adc = 1'b1;
        bus.i_bist_hv_ot  = 1'b1;
        r = cyc + 1;
        flag_q.push_back('{item: 1, cyc: r + FLT_DLY});
        adc_q.push_back('{cyc: r + ADC_DLY, d1: 10'h200, d2: 10'h200});
        wait_flags(FLT_DLY + 20, "conc_ot_timeout");
        wait_adc(ADC_DLY + 20, "conc_adc_timeout");
        check_output("conc_ot_high", bus.o_hv_ot, 1'b1);
        @(negedge clk);
        bus.i_bist_hv_adc = 1'b0;
        bus.i_bist_hv_ot  = 1'b0;
        @(negedge clk);
        check_output("conc_all_low", {mon_f, bus.o_hv_adc_rdy1}, 6'b0);
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hv_abist_rsp.md
HV_ABIST_RSP -- requirements
Module: hv_abist_rsp

Interface
REQ-001 Parameters come from the shared parameter include (CLK_M = clock MHz, ADC_DW = ADC width), plus the local parameters in REQ-002 to REQ-007.
REQ-002 OV_DLY, default 10*CLK_M: OV flag response delay in cycles.
REQ-003 FLT_DLY, default CLK_M/2: response delay in cycles for OT, DESAT, OC and SCP.
REQ-004 ADC_DLY, default 20*CLK_M: cycles from ADC request to the first sample.
REQ-005 ADC_PER, default 4*CLK_M: cycles between ADC samples.
REQ-006 ADC_MID, default 10'h200: nominal ADC code.
REQ-007 ADC_BAD, default 10'h000: ADC code emitted under fault injection.
REQ-008 i_clk  in  1  sole clock.
REQ-009 i_rst  in  1  reset; asynchronous, active-high.
REQ-010 i_bist_hv_ov / _ot / _opscod / _oc / _sc / _adc  in  1 each  per-item BIST stimulus requests, item index 0..5 in that order.
REQ-011 i_fault_inj  in  6  per-item forced-fail enable; bit i maps to item i.
REQ-012 o_hv_vcc_ov, o_hv_ot, o_hv_desat_flt, o_hv_oc, o_hv_scp_flt  out  1 each  emulated analog fault flags for items 0..4.
REQ-013 o_hv_adc_rdy1, o_hv_adc_rdy2  out  1 each  ADC sample-valid pulses.
REQ-014 o_hv_adc_data1, o_hv_adc_data2  out  ADC_DW each  ADC sample codes.

Function
REQ-015 Each request input is registered once; a request "rise" is the registered value low with the input high.
REQ-016 Flag items 0..4 each run an independent FSM with states IDLE, WAIT, ASSERT and HOLD.
REQ-017 Transitions for items 0..4:
- IDLE->WAIT on request rise with i_fault_inj[i]=0; the per-item counter clears to 0.
- IDLE->HOLD on request rise with i_fault_inj[i]=1.
REQ-018 In WAIT the counter increments each cycle; at count DLY-1 the FSM goes to ASSERT, so the flag is first high exactly DLY cycles after the rise cycle (DLY = OV_DLY for item 0, FLT_DLY for items 1..4).
REQ-019 Request low in WAIT or HOLD -> IDLE with the flag low (abort, no response).
REQ-020 In ASSERT the flag is high; request low -> IDLE, and the flag drops on that same edge (one cycle after the request falls).
REQ-021 i_fault_inj is sampled only at the rise; changes mid-request are ignored.
REQ-022 Flag outputs are registered, glitch-free, and deasserted in every state other than ASSERT.
REQ-023 The counter saturates at its maximum; its width is $clog2(max(OV_DLY, FLT_DLY, ADC_DLY, ADC_PER)+1).
REQ-024 ADC FSM states are IDLE, FIRST and PERIODIC:
- request rise -> FIRST, counter cleared.
- FIRST: after ADC_DLY cycles, one-cycle rdy1/rdy2 pulse, then PERIODIC.
- PERIODIC: one rdy pulse every ADC_PER cycles while the request stays high.
REQ-025 rdy1 and rdy2 always pulse in the same cycle.
REQ-026 ADC data values:
- data1 alternates ADC_MID, ADC_MID+1 on successive samples, starting with ADC_MID.
- data2 alternates ADC_MID, ADC_MID-1, starting with ADC_MID.
- Data is updated on the same edge as rdy and held between pulses.
REQ-027 With i_fault_inj[5]=1 sampled at the rise, data1 and data2 are ADC_BAD on every sample; rdy timing is unchanged.
REQ-028 ADC request low in any state -> IDLE; rdy goes low and data goes to 0 on the next edge. A pending sample is discarded.
REQ-029 A request that falls and rises again in consecutive cycles restarts timing from the new rise.
REQ-030 Multiple simultaneous requests are served independently with no arbitration.

Reset
REQ-031 While i_rst=1, all FSMs are IDLE, counters and registered requests are 0, all flags and rdy outputs are 0, and data outputs are 0.
REQ-032 Assertion of i_rst mid-operation takes effect immediately (asynchronous); on release, all blocks wait for a fresh request rise.

Verification (CLK_M=48)
REQ-033 i_bist_hv_ov rises, held high, no fault injection -> o_hv_vcc_ov is first high at rise+480 cycles; the request is dropped 1 cycle later -> the flag is low on the next edge.
REQ-034 i_bist_hv_oc held high with i_fault_inj[3]=1 -> o_hv_oc stays 0 for 2000 cycles; request low -> FSM back in IDLE.
REQ-035 i_bist_hv_adc held high -> first rdy1/rdy2 pulse at rise+960 cycles with data 0x200/0x200, second at +1152 cycles with 0x201/0x1FF, third with 0x200/0x200.
REQ-036 i_bist_hv_ot pulsed high for 10 cycles -> o_hv_ot never asserts; a re-request 1 cycle later asserts the flag at new rise+24 cycles.
REQ-037 i_rst asserted at cycle 300 of an OV wait -> o_hv_vcc_ov stays 0; after release, the still-high request produces no flag until a fresh rise.
REQ-038 ADC request with i_fault_inj[5]=1 -> data 0x000 on both channels at every rdy pulse; ADC and OT requests concurrent -> both respond with nominal timing.
